// File: rtl/nios_led_pwm.sv
// nios_led_pwm: Avalon-MM controlled PWM dimmer and blinker for an 8-bit LED bank.
// Optional build macro NIOS_LED_PWM_GAMMA_EN squares the duty value (gamma
// correction) when it is loaded into the active shadow; the register map is unchanged.
module nios_led_pwm #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  pattern,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  led
);

  localparam int unsigned PRE_W   = 16;
  localparam int unsigned PWM_W   = 8;
  localparam int unsigned BLINK_W = 16;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(254);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_BLINK  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // Architectural registers and their next-state values
  logic [1:0]         ctrl_q,      ctrl_d;
  logic [7:0]         duty_q,      duty_d;
  logic [BLINK_W-1:0] blink_div_q, blink_div_d;
  logic [7:0]         pattern_q,   pattern_d;
  logic [7:0]         duty_act_q,  duty_act_d;
  logic [PRE_W-1:0]   pre_cnt_q,   pre_cnt_d;
  logic [PWM_W-1:0]   pwm_cnt_q,   pwm_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q,     phase_d;
  logic [7:0]         led_q,       led_d;

  logic       wr_c;
  logic       wr_ctrl_c;
  logic       wr_duty_c;
  logic       wr_blink_c;
  logic       enable_c;
  logic       enable_rise_c;
  logic       tick_c;
  logic       boundary_c;
  logic       load_c;
  logic       pwm_on_c;
  logic       blink_gate_c;
  logic [7:0] duty_map_c;
  logic       unused_wdata_c;

  // Avalon write decode; the upper data bits carry no register content
  assign wr_c           = chipselect & ~write_n;
  assign wr_ctrl_c      = wr_c & (address == ADDR_CTRL);
  assign wr_duty_c      = wr_c & (address == ADDR_DUTY);
  assign wr_blink_c     = wr_c & (address == ADDR_BLINK);
  assign unused_wdata_c = ^writedata[31:16];

  // Timing strobes: prescaler tick, period boundary, and shadow-load events
  assign enable_c      = ctrl_q[0];
  assign enable_rise_c = wr_ctrl_c & writedata[0] & ~ctrl_q[0];
  assign tick_c        = enable_c & (pre_cnt_q == PRE_LAST);
  assign boundary_c    = tick_c & (pwm_cnt_q == PWM_LAST);
  assign load_c        = boundary_c | enable_rise_c;

  // Output gating terms
  assign pwm_on_c     = (pwm_cnt_q < duty_act_q);
  assign blink_gate_c = ctrl_q[1] ? phase_q : 1'b1;

`ifdef NIOS_LED_PWM_GAMMA_EN
  logic [15:0] duty_sq_c;
  // Square-law duty map; full scale stays full scale so 255 remains always-on
  assign duty_sq_c  = {8'h00, duty_q} * {8'h00, duty_q};
  assign duty_map_c = (duty_q == 8'hFF) ? 8'hFF : duty_sq_c[15:8];
`else
  // Linear duty map
  assign duty_map_c = duty_q;
`endif

  // Next-state logic for registers, counters and LED drive
  always_comb begin
    ctrl_d      = ctrl_q;
    duty_d      = duty_q;
    blink_div_d = blink_div_q;
    pattern_d   = pattern_q;
    duty_act_d  = duty_act_q;
    pre_cnt_d   = pre_cnt_q;
    pwm_cnt_d   = pwm_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    led_d       = 8'h00;

    if (wr_ctrl_c)  ctrl_d      = writedata[1:0];
    if (wr_duty_c)  duty_d      = writedata[7:0];
    if (wr_blink_c) blink_div_d = writedata[BLINK_W-1:0];

    // Shadows only change at a period boundary or when the PWM starts
    if (load_c) begin
      pattern_d  = pattern;
      duty_act_d = duty_map_c;
    end

    if (!enable_c) begin
      pre_cnt_d   = '0;
      pwm_cnt_d   = '0;
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else begin
      pre_cnt_d = tick_c ? '0 : pre_cnt_q + PRE_W'(1);
      if (tick_c) begin
        pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_W'(1);
      end
      // A BLINK_DIV write restarts the blink cycle in the lit phase
      if (wr_blink_c) begin
        blink_cnt_d = '0;
        phase_d     = 1'b1;
      end else if (boundary_c) begin
        if (blink_div_q == '0) begin
          blink_cnt_d = '0;
          phase_d     = 1'b1;
        end else if ((blink_cnt_q + BLINK_W'(1)) == blink_div_q) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
      end
    end

    if (enable_c && pwm_on_c && blink_gate_c) led_d = pattern_q;
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_q      <= 2'b00;
      duty_q      <= 8'hFF;
      blink_div_q <= '0;
      pattern_q   <= 8'h00;
      duty_act_q  <= 8'hFF;
      pre_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      led_q       <= 8'h00;
    end else begin
      ctrl_q      <= ctrl_d;
      duty_q      <= duty_d;
      blink_div_q <= blink_div_d;
      pattern_q   <= pattern_d;
      duty_act_q  <= duty_act_d;
      pre_cnt_q   <= pre_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
    end
  end

  // Zero-latency register readback; DUTY returns the written value, not the shadow
  always_comb begin
    readdata = 32'h0000_0000;
    case (address)
      ADDR_CTRL:   readdata = {30'd0, ctrl_q};
      ADDR_DUTY:   readdata = {24'd0, duty_q};
      ADDR_BLINK:  readdata = {16'd0, blink_div_q};
      ADDR_STATUS: readdata = {23'd0, phase_q, pattern_q};
      default:     readdata = 32'h0000_0000;
    endcase
  end

  assign led = led_q;

endmodule

// File: tb/tb_nios_led_pwm.sv
// Directed bench for nios_led_pwm at PRESCALE=1 (one PWM step per clock, 255-clock period).
module tb_nios_led_pwm;

  logic        clk;
  logic        reset_n;
  logic [7:0]  pattern;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  led;

  int total;
  int bad;

  nios_led_pwm #(.PRESCALE(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pattern    (pattern),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .led        (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic        cs;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  // Active duty for a written DUTY value, as the build is configured
  function automatic int eff(input int d);
`ifdef NIOS_LED_PWM_GAMMA_EN
    return (d == 255) ? 255 : ((d * d) >> 8);
`else
    return d;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge
  task automatic do_reset();
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic run_count(input int n, input logic [7:0] lit, output int nlit, output int nzero);
    nlit  = 0;
    nzero = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (led == lit) nlit++;
      else if (led == 8'h00) nzero++;
    end
  endtask

  initial begin
    int nl;
    int nz;
    int e;
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    pattern    = 8'h3C;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;

    vecs[0]  = '{"rst_ctrl",    1'b0, 1'b1, 2'd0, 32'h0,         32'h0};
    vecs[1]  = '{"rst_duty",    1'b0, 1'b1, 2'd1, 32'h0,         32'hFF};
    vecs[2]  = '{"rst_bdiv",    1'b0, 1'b1, 2'd2, 32'h0,         32'h0};
    vecs[3]  = '{"rst_status",  1'b0, 1'b1, 2'd3, 32'h0,         32'h100};
    vecs[4]  = '{"wr_duty",     1'b1, 1'b1, 2'd1, 32'hFFFF_FF40, 32'h40};
    vecs[5]  = '{"wr_no_cs",    1'b1, 1'b0, 2'd1, 32'h0000_0011, 32'h40};
    vecs[6]  = '{"wr_bdiv",     1'b1, 1'b1, 2'd2, 32'hABCD_0003, 32'h3};
    vecs[7]  = '{"wr_ctrl_hi",  1'b1, 1'b1, 2'd0, 32'hFFFF_FFFE, 32'h2};
    vecs[8]  = '{"wr_status",   1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h100};
    vecs[9]  = '{"wr_ctrl_0",   1'b1, 1'b1, 2'd0, 32'h0,         32'h0};
    vecs[10] = '{"wr_bdiv_0",   1'b1, 1'b1, 2'd2, 32'h0,         32'h0};
    vecs[11] = '{"rd_duty_kept",1'b0, 1'b1, 2'd1, 32'h0,         32'h40};

    // Register map vectors (PWM disabled throughout)
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("rst_led", 32'(led), 32'h0);
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        address    = vecs[i].addr;
        writedata  = vecs[i].wdata;
        chipselect = vecs[i].cs;
        write_n    = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
      end
      address = vecs[i].addr;
      #1;
      check(vecs[i].name, readdata, vecs[i].exp_rd);
      check("led_disabled", 32'(led), 32'h0);
    end

    // DUTY=64 steady state, then DUTY=0 and DUTY=255
    do_reset();
    pattern = 8'hA5;
    bus_wr(2'd1, 32'd64);
    bus_wr(2'd0, 32'd1);
    run_count(255, 8'hA5, nl, nz);
    run_count(255, 8'hA5, nl, nz);
    e = eff(64);
    check("d64_lit", 32'(nl), 32'(e));
    check("d64_dark", 32'(nz), 32'(255 - e));
    bus_wr(2'd1, 32'd0);
    run_count(255, 8'hA5, nl, nz);
    run_count(255, 8'hA5, nl, nz);
    check("d0_lit", 32'(nl), 32'd0);
    check("d0_dark", 32'(nz), 32'd255);
    bus_wr(2'd1, 32'd255);
    run_count(255, 8'hA5, nl, nz);
    run_count(255, 8'hA5, nl, nz);
    check("d255_lit", 32'(nl), 32'd255);
    check("d255_dark", 32'(nz), 32'd0);

    // Blink with BLINK_DIV=2: two periods lit, two dark
    do_reset();
    pattern = 8'hFF;
    bus_wr(2'd2, 32'd2);
    bus_wr(2'd0, 32'd3);
    address = 2'd3;
    run_count(510, 8'hFF, nl, nz);
    check("blink_on1", 32'(nl), 32'd510);
    check("blink_ph0", 32'(readdata[8]), 32'd0);
    run_count(510, 8'hFF, nl, nz);
    check("blink_off", 32'(nz), 32'd510);
    check("blink_ph1", 32'(readdata[8]), 32'd1);
    run_count(510, 8'hFF, nl, nz);
    check("blink_on2", 32'(nl), 32'd510);
    check("blink_ph0b", readdata, 32'h0FF);
    bus_wr(2'd0, 32'd2);
    @(posedge clk); #1;
    check("dis_led", 32'(led), 32'h0);
    address = 2'd3;
    #1;
    check("dis_phase", readdata, 32'h1FF);

    // DUTY 200 -> 10 rewritten at PWM count 100
    do_reset();
    pattern = 8'hFF;
    bus_wr(2'd1, 32'd200);
    bus_wr(2'd0, 32'd1);
    run_count(99, 8'hFF, nl, nz);
    check("d200_head", 32'(nl), 32'd99);
    bus_wr(2'd1, 32'd10);
    run_count(155, 8'hFF, nl, nz);
    e = eff(200) > 100 ? eff(200) - 100 : 0;
    check("d200_tail_lit", 32'(nl), 32'(e));
    check("d200_tail_dark", 32'(nz), 32'(155 - e));
    run_count(255, 8'hFF, nl, nz);
    check("d10_lit", 32'(nl), 32'(eff(10)));
    check("d10_dark", 32'(nz), 32'(255 - eff(10)));

    // Pattern change mid-period is deferred to the boundary
    do_reset();
    pattern = 8'h0F;
    bus_wr(2'd0, 32'd1);
    run_count(100, 8'h0F, nl, nz);
    check("pat_head", 32'(nl), 32'd100);
    pattern = 8'hF0;
    address = 2'd3;
    #1;
    check("pat_status_old", readdata, 32'h10F);
    run_count(155, 8'h0F, nl, nz);
    check("pat_tail", 32'(nl), 32'd155);
    check("pat_status_new", readdata, 32'h1F0);
    @(posedge clk); #1;
    check("pat_led_new", 32'(led), 32'hF0);

    // One-cycle reset while lit, colliding with a DUTY write
    bus_wr(2'd1, 32'd77);
    reset_n    = 1'b0;
    address    = 2'd1;
    writedata  = 32'h12;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk); #1;
    reset_n    = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    check("rst_mid_led", 32'(led), 32'h0);
    address = 2'd0; #1;
    check("rst_mid_ctrl", readdata, 32'h0);
    address = 2'd1; #1;
    check("rst_mid_duty", readdata, 32'hFF);
    address = 2'd3; #1;
    check("rst_mid_status", readdata, 32'h100);
    run_count(20, 8'hF0, nl, nz);
    check("rst_mid_dark", 32'(nz), 32'd20);

    // DUTY=128 lit count (64 with gamma correction)
    do_reset();
    pattern = 8'hFF;
    bus_wr(2'd1, 32'd128);
    bus_wr(2'd0, 32'd1);
    run_count(255, 8'hFF, nl, nz);
    check("d128_lit", 32'(nl), 32'(eff(128)));
    check("d128_dark", 32'(nz), 32'(255 - eff(128)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nios_led_pwm.md
NIOS_LED_PWM -- requirements
Module: nios_led_pwm

Interface
REQ-001 Parameter PRESCALE, default 4: clk cycles per PWM tick, legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 pattern  input  8  LED on/off pattern from the upstream LED PIO output port, same clock domain.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  Avalon-MM slave select.
REQ-007 write_n  input  1  Avalon-MM active-low write strobe.
REQ-008 writedata  input  32  Avalon-MM write data.
REQ-009 readdata  output  32  Avalon-MM read data, combinational from address, zero-latency.
REQ-010 led  output  8  registered drive to the physical LEDs, 1 = lit.

Function
REQ-011 Register map: 0 CTRL (bit0 enable, bit1 blink_en); 1 DUTY [7:0]; 2 BLINK_DIV [15:0]; 3 STATUS (read-only: [7:0] pattern_q, [8] blink phase).
REQ-012 Write on rising clk when chipselect=1 and write_n=0; unused writedata bits ignored; writes to address 3 ignored.
REQ-013 readdata zero-extends the addressed register; DUTY readback returns the last written value, not the active shadow.
REQ-014 Prescaler counts 0..PRESCALE-1 and asserts a one-cycle tick on reaching PRESCALE-1, then wraps to 0.
REQ-015 PWM counter, 8 bits, advances on each tick, counts 0..254 and wraps to 0; PWM period = 255*PRESCALE clk cycles.
REQ-016 At each period boundary (tick with PWM counter = 254): pattern_q <= pattern and duty_act <= DUTY.
REQ-017 pwm_on = (PWM counter < duty_act); duty_act 0 gives never on; 255 gives always on.
REQ-018 Blink counter counts completed PWM periods; on reaching BLINK_DIV it clears and toggles phase.
REQ-019 BLINK_DIV = 0 holds phase at 1 and the blink counter at 0.
REQ-020 Any write to BLINK_DIV clears the blink counter and sets phase to 1 on the same edge.
REQ-021 Next-cycle led = enable & pattern_q & {8{pwm_on}} & {8{blink_en ? phase : 1}}; one clk latency.
REQ-022 While enable = 0: prescaler, PWM counter and blink counter are held at 0, phase at 1, led at 0.
REQ-023 When enable rises: counting restarts from 0, and pattern_q and duty_act load on that same edge.
REQ-024 A DUTY write mid-period takes effect only at the next period boundary; there is no partial-period glitch.

Reset
REQ-025 On reset_n = 0 at a clock edge: CTRL = 0, DUTY = 0xFF, duty_act = 0xFF, BLINK_DIV = 0, pattern_q = 0, all counters = 0, phase = 1, led = 0.
REQ-026 Reset overrides a simultaneous Avalon write; reset mid-period aborts the period with no residual output.

Configuration
REQ-027 Macro NIOS_LED_PWM_GAMMA_EN: when defined, duty_act loads (DUTY*DUTY)>>8, except DUTY = 255, which loads 255.
REQ-028 Without NIOS_LED_PWM_GAMMA_EN, duty_act loads DUTY unchanged; register map and readback are identical in both builds.

Verification
REQ-029 PRESCALE=1, reset released, write CTRL=1, pattern=0xA5, DUTY=64 -> from the second full period onward, led=0xA5 for 64 of every 255 clocks, 0x00 otherwise.
REQ-030 DUTY=0 -> led stays 0x00; DUTY=255 -> led holds pattern continuously with no low clock.
REQ-031 CTRL=3, BLINK_DIV=2, DUTY=255, pattern=0xFF -> led alternates 0xFF for 2 periods and 0x00 for 2 periods (510 clocks each at PRESCALE=1); STATUS[8] tracks the phase.
REQ-032 Write DUTY 200 -> 10 at PWM count 100 -> current period stays high until count 200; next period is high for counts 0..9.
REQ-033 Pattern changes 0x0F -> 0xF0 mid-period -> led keeps 0x0F until the boundary; STATUS[7:0] reads 0xF0 after the boundary.
REQ-034 reset_n low for 1 clk during a lit phase -> led=0x00 next cycle, CTRL reads 0, DUTY reads 0xFF; with GAMMA_EN, DUTY=128 gives 64 lit clocks per period.
